alu_arbiter: RTL and testbench

- Shares one combinational ALU (8 ops, 3-bit select, Result/CarryOut/Zero outputs) among NUM_REQ requesters.
- Round-robin grant; operands are latched and driven to the ALU for one cycle, and the result is captured and returned on a shared response channel with a valid/ready handshake.
- Sits between requesting datapath units and the ALU instance; the ALU is instantiated outside this block.

---
 rtl/alu_arbiter.sv | 152 +++++++++++++++
 tb/tb_alu_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Round-robin arbiter that lets NUM_REQ requesters share one external
//   combinational ALU. A granted request's operands are latched onto alu_*,
//   held for one EXEC cycle, and the ALU outputs are then captured onto a
//   single valid/ready response channel tagged with the owner's index.
//
//   Optional build macro: ALU_ARB_STATS_EN adds op_count / zero_count
//   (16-bit wrapping response-handshake counters).
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   req_valid/req_ready    per-requester handshake (req_ready one-hot or 0)
//   req_a/req_b/req_op     flat per-requester operands, slice i = requester i
//   alu_a/alu_b/alu_sel    latched operands to the external ALU
//   alu_result/carry/zero  ALU outputs, sampled at the end of EXEC
//   rsp_valid/rsp_ready    response handshake
//   rsp_id/result/carry/zero  captured response
//   op_count, zero_count   (ALU_ARB_STATS_EN only) handshake statistics
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*3-1:0]     req_op,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [2:0]               alu_sel,
  input  logic [WIDTH-1:0]         alu_result,
  input  logic                     alu_carry,
  input  logic                     alu_zero,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_carry,
  output logic                     rsp_zero
`ifdef ALU_ARB_STATS_EN
  ,output logic [15:0]             op_count
  ,output logic [15:0]             zero_count
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                      state_q;
  logic [ID_W-1:0]             ptr_q;
  logic [ID_W-1:0]             own_q;
  logic [ID_W-1:0]             gnt;
  logic                        any_vld;
  int                          rr_idx;

  // Packed per-requester views of the flat operand buses.
  logic [NUM_REQ-1:0][WIDTH-1:0] a_v;
  logic [NUM_REQ-1:0][WIDTH-1:0] b_v;
  logic [NUM_REQ-1:0][2:0]       op_v;

  assign a_v  = req_a;
  assign b_v  = req_b;
  assign op_v = req_op;

  // First valid requester at or above ptr_q, wrapping past NUM_REQ-1.
  always_comb begin
    gnt     = '0;
    any_vld = 1'b0;
    rr_idx  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_idx = int'(ptr_q) + k;
      if (rr_idx >= NUM_REQ) rr_idx = rr_idx - NUM_REQ;
      if (!any_vld && req_valid[rr_idx]) begin
        any_vld = 1'b1;
        gnt     = ID_W'(rr_idx);
      end
    end
  end

  // Gated by rst so the grant cannot show while reset is held.
  assign req_ready = (state_q == IDLE && any_vld && !rst)
                     ? (NUM_REQ'(1) << gnt) : '0;

  wire rsp_hs = (state_q == RESP) && rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      own_q      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (any_vld) begin
          alu_a   <= a_v[gnt];
          alu_b   <= b_v[gnt];
          alu_sel <= op_v[gnt];
          own_q   <= gnt;
          state_q <= EXEC;
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_carry  <= alu_carry;
          rsp_zero   <= alu_zero;
          rsp_id     <= own_q;
          rsp_valid  <= 1'b1;
          state_q    <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          ptr_q     <= (own_q == ID_W'(NUM_REQ-1)) ? '0 : own_q + 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [15:0] op_cnt_q;
  logic [15:0] zero_cnt_q;

  // Plain 16-bit adders wrap 0xFFFF -> 0 naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_cnt_q   <= '0;
      zero_cnt_q <= '0;
    end else if (rsp_hs) begin
      op_cnt_q <= op_cnt_q + 16'd1;
      if (rsp_zero) zero_cnt_q <= zero_cnt_q + 16'd1;
    end
  end

  assign op_count   = op_cnt_q;
  assign zero_count = zero_cnt_q;
`else
  logic unused_hs;
  assign unused_hs = rsp_hs;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  localparam int W = 8;
  localparam int N = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N*3-1:0] req_op = '0;
  logic [W-1:0]   alu_a, alu_b, alu_result;
  logic [2:0]     alu_sel;
  logic           alu_carry, alu_zero;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [IW-1:0]  rsp_id;
  logic [W-1:0]   rsp_result;
  logic           rsp_carry, rsp_zero;
`ifdef ALU_ARB_STATS_EN
  logic [15:0]    op_count, zero_count;
`endif

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W), .NUM_REQ(N), .ID_W(IW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero)
`ifdef ALU_ARB_STATS_EN
    , .op_count(op_count), .zero_count(zero_count)
`endif
  );

  // External ALU: 0 ADD, 1 SUB (carry = borrow), 2 AND, 3 OR, 4 XOR, 5 NOR,
  // 6 SLT, 7 pass B.
  logic [W:0] m_sum;
  always_comb begin
    m_sum = '0;
    case (alu_sel)
      3'd0: m_sum = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: m_sum = {1'b0, alu_a} - {1'b0, alu_b};
      3'd2: m_sum = {1'b0, alu_a & alu_b};
      3'd3: m_sum = {1'b0, alu_a | alu_b};
      3'd4: m_sum = {1'b0, alu_a ^ alu_b};
      3'd5: m_sum = {1'b0, ~(alu_a | alu_b)};
      3'd6: m_sum = {{W{1'b0}}, alu_a < alu_b};
      default: m_sum = {1'b0, alu_b};
    endcase
  end
  assign alu_result = m_sum[W-1:0];
  assign alu_carry  = m_sum[W];
  assign alu_zero   = (m_sum[W-1:0] == '0);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic pulse_rst();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_op[i*3 +: 3] = op;
    req_valid[i] = 1'b1;
  endtask

  // One full transaction from requester i with rsp_ready held high.
  task automatic run_op(input string tag, input int i, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2:0] op,
                        input logic [W-1:0] er, input logic ec, input logic ez);
    int n;
    @(negedge clk);
    set_req(i, a, b, op);
    n = 0;
    #1;
    while (!req_ready[i] && n < 20) begin @(negedge clk); #1; n++; end
    chk({tag, "_gnt"}, 32'(req_ready), 32'(1 << i));
    @(negedge clk);
    req_valid[i] = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 10);
    chk({tag, "_lat"}, n, 1);
    chk({tag, "_res"}, rsp_result, er);
    chk({tag, "_c"},   rsp_carry, ec);
    chk({tag, "_z"},   rsp_zero, ez);
    chk({tag, "_id"},  rsp_id, i);
    @(negedge clk);
    chk({tag, "_clr"}, rsp_valid, 0);
  endtask

  initial begin
    int gid[5];
    int gcy[5];
    int ng;
    int n;

    // Reset state
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_vld",   rsp_valid, 0);
    chk("rst_alu",   {alu_a, alu_b, 5'(alu_sel)}, 0);
    chk("rst_rsp",   {rsp_result, rsp_carry, rsp_zero, 6'(rsp_id)}, 0);
    rst = 1'b0;

    // 1: single ADD
    run_op("t1", 0, 8'h0F, 8'h01, 3'd0, 8'h10, 1'b0, 1'b0);

    // 2: all requesters held valid, grant order and spacing
    pulse_rst();
    for (int i = 0; i < N; i++) set_req(i, 8'(i + 1), 8'h00, 3'd0);
    ng = 0;
    for (int c = 0; c < 40 && ng < 5; c++) begin
      #1;
      if (req_ready != 0) begin
        gid[ng] = $clog2(int'(req_ready));
        gcy[ng] = c;
        ng++;
      end
      @(negedge clk);
    end
    chk("t2_ngrants", ng, 5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t2_order%0d", k), gid[k], k % N);
      if (k > 0) chk($sformatf("t2_gap%0d", k), gcy[k] - gcy[k-1], 3);
    end
    req_valid = '0;
    repeat (4) @(negedge clk);

    // 3: backpressure; pointer now 1 after owner 0
    rsp_ready = 1'b0;
    set_req(1, 8'h03, 8'h04, 3'd0);
    set_req(2, 8'hF0, 8'h3C, 3'd2);
    #1;
    chk("t3_gnt1", req_ready, 4'b0010);
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("t3_hold%0d", c),
          {rsp_valid, 2'(rsp_id), rsp_result, 4'(req_ready)}, {1'b1, 2'd1, 8'h07, 4'h0});
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("t3_gnt2", req_ready, 4'b0100);
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(negedge clk);
    chk("t3_rsp2", {rsp_valid, 2'(rsp_id), rsp_result}, {1'b1, 2'd2, 8'h30});
    @(negedge clk);

    // 4: flags
    run_op("t4_add", 0, 8'hFF, 8'h01, 3'd0, 8'h00, 1'b1, 1'b1);
    run_op("t4_sub", 1, 8'h05, 8'h05, 3'd1, 8'h00, 1'b0, 1'b1);
    run_op("t4_nor", 2, 8'h00, 8'h00, 3'd5, 8'hFF, 1'b0, 1'b0);

    // 5: reset during EXEC with req3 still valid
    @(negedge clk);
    set_req(3, 8'hA5, 8'h5A, 3'd4);
    #1;
    chk("t5_gnt", req_ready, 4'b1000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_rst_alu", {alu_a, alu_b, 5'(alu_sel)}, 0);
    chk("t5_rst_out", {rsp_valid, 4'(req_ready), rsp_result}, 0);
    @(negedge clk);
    chk("t5_norsp", rsp_valid, 0);
    rst = 1'b0;
    #1;
    chk("t5_regnt", req_ready, 4'b1000);
    @(negedge clk);
    req_valid[3] = 1'b0;
    @(negedge clk);
    chk("t5_rsp", {rsp_valid, 2'(rsp_id), rsp_result, rsp_zero}, {1'b1, 2'd3, 8'hFF, 1'b0});
    @(negedge clk);

`ifdef ALU_ARB_STATS_EN
    // 6: statistics
    pulse_rst();
    run_op("t6_a", 0, 8'h01, 8'h01, 3'd0, 8'h02, 1'b0, 1'b0);
    run_op("t6_b", 1, 8'h03, 8'h03, 3'd1, 8'h00, 1'b0, 1'b1);
    run_op("t6_c", 2, 8'h01, 8'h02, 3'd3, 8'h03, 1'b0, 1'b0);
    chk("t6_ops",   op_count, 3);
    chk("t6_zeros", zero_count, 1);
    force dut.op_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.op_cnt_q;
    run_op("t6_w", 0, 8'h01, 8'h00, 3'd0, 8'h01, 1'b0, 1'b0);
    chk("t6_wrap", op_count, 0);
`endif

    n = n_chk - n_pass;
    if (n < 0) $display("FAIL count: bad tally");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end
endmodule
